// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - controller that loads and sequences a seq pattern generator (optional SEQ_CTRL_INFINITE_EN)
module seq_ctrl #(
    parameter int BW_SEQ     = 4,
    parameter int SEQ_CNT    = 7,
    parameter int BW_SEQ_CNT = 3,
    parameter int BW_TIMEOUT = 2,
    parameter int BW_REP     = 8
) (
    input  logic                                             CLK,
    input  logic                                             RSTX,
    input  logic                                             WE,
    input  logic [BW_SEQ_CNT-1:0]                            WADDR,
    input  logic [BW_SEQ+BW_TIMEOUT-1:0]                     WDATA,
    input  logic                                             START,
    input  logic                                             STOP,
    input  logic [BW_REP-1:0]                                REP,
    output logic [(BW_SEQ+BW_TIMEOUT)*(SEQ_CNT+1)-1:0]       PTN,
    output logic                                             CLR,
    output logic                                             BUSY,
    output logic                                             DONE,
    output logic                                             ABORT,
    output logic [BW_REP-1:0]                                REP_LEFT
);

    localparam int W  = BW_SEQ + BW_TIMEOUT;
    localparam int PW = W * (SEQ_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           shadow_q;
    logic [PW-1:0]           ptn_q, ptn_d;
    logic [BW_SEQ_CNT-1:0]   idx_q, idx_d, idx_m1;
    logic [BW_TIMEOUT-1:0]   timer_q, timer_d;
    logic [BW_REP-1:0]       rep_q, rep_d;
    logic                    clr_q;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
`ifdef SEQ_CTRL_INFINITE_EN
    logic                    inf_q, inf_d;
`endif

    assign idx_m1 = idx_q - BW_SEQ_CNT'(1);

    // Shadow table: host writes land here in any state; an index past the last entry matches nothing
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            shadow_q <= '0;
        end else if (WE) begin
            for (int e = 0; e <= SEQ_CNT; e++) begin
                if (WADDR == BW_SEQ_CNT'(e)) begin
                    shadow_q[e*W +: W] <= WDATA;
                end
            end
        end
    end

    // Next-state logic: snapshot on START, walk entries from the top index down, count passes
    always_comb begin
        state_d = state_q;
        ptn_d   = ptn_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
`ifdef SEQ_CTRL_INFINITE_EN
        inf_d   = inf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    ptn_d   = shadow_q;
                    state_d = S_LOAD;
`ifdef SEQ_CTRL_INFINITE_EN
                    inf_d   = (REP == '0);
                    rep_d   = REP;
`else
                    rep_d   = (REP == '0) ? BW_REP'(1) : REP;
`endif
                end
            end
            S_LOAD: begin
                if (STOP) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    rep_d   = '0;
                end else begin
                    idx_d   = BW_SEQ_CNT'(SEQ_CNT);
                    timer_d = ptn_q[SEQ_CNT*W +: BW_TIMEOUT];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (STOP) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    rep_d   = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - BW_TIMEOUT'(1);
                end else if (idx_q != '0) begin
                    idx_d   = idx_m1;
                    timer_d = ptn_q[int'(idx_m1)*W +: BW_TIMEOUT];
                end else begin
`ifdef SEQ_CTRL_INFINITE_EN
                    if (inf_q) begin
                        state_d = S_LOAD;
                    end else
`endif
                    if (rep_q == BW_REP'(1)) begin
                        rep_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rep_d   = rep_q - BW_REP'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; CLR follows the next state so it is low exactly while in RUN
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            state_q <= S_IDLE;
            ptn_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            rep_q   <= '0;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef SEQ_CTRL_INFINITE_EN
            inf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptn_q   <= ptn_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            clr_q   <= (state_d != S_RUN);
            done_q  <= done_d;
            abort_q <= abort_d;
`ifdef SEQ_CTRL_INFINITE_EN
            inf_q   <= inf_d;
`endif
        end
    end

    assign PTN      = ptn_q;
    assign CLR      = clr_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign ABORT    = abort_q;
    assign REP_LEFT = rep_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl
module tb_seq_ctrl;

    logic        CLK   = 1'b0;
    logic        RSTX  = 1'b0;
    logic        WE    = 1'b0;
    logic [2:0]  WADDR = '0;
    logic [5:0]  WDATA = '0;
    logic        START = 1'b0;
    logic        STOP  = 1'b0;
    logic [7:0]  REP   = '0;
    logic [47:0] PTN;
    logic        CLR, BUSY, DONE, ABORT;
    logic [7:0]  REP_LEFT;

    seq_ctrl dut (
        .CLK(CLK), .RSTX(RSTX), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .START(START), .STOP(STOP), .REP(REP), .PTN(PTN), .CLR(CLR),
        .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT), .REP_LEFT(REP_LEFT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       clr;
        logic       busy;
        logic       done;
        logic       abort;
        logic [7:0] rep_left;
    } obs_t;

    typedef struct {
        logic [15:0] tmo;
        logic [7:0]  rep;
        int          stop_at;
        bit          poke;
        int          exp_busy;
        bit          exp_done;
        bit          exp_abort;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [5:0]  sh [8];
    obs_t        exp_q [$];
    vec_t        vecs [8];

    function automatic obs_t mk(input logic c, input logic b, input logic d, input logic a, input int rl);
        obs_t o;
        o.clr = c; o.busy = b; o.done = d; o.abort = a; o.rep_left = 8'(rl);
        return o;
    endfunction

    function automatic logic [47:0] pack_sh();
        logic [47:0] v;
        for (int i = 0; i < 8; i++) v[i*6 +: 6] = sh[i];
        return v;
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t e, input logic [47:0] eptn);
        obs_t a;
        a = mk(CLR, BUSY, DONE, ABORT, int'(REP_LEFT));
        checks++;
        if (a !== e || PTN !== eptn) begin
            failures++;
            $display("FAIL %s cyc%0d: got clr=%b busy=%b done=%b abort=%b rep_left=%0d ptn=%h, want clr=%b busy=%b done=%b abort=%b rep_left=%0d ptn=%h",
                     name, cyc, a.clr, a.busy, a.done, a.abort, a.rep_left, PTN,
                     e.clr, e.busy, e.done, e.abort, e.rep_left, eptn);
        end
    endtask

    task automatic write_entry(input int i, input logic [5:0] v);
        WE = 1'b1; WADDR = 3'(i); WDATA = v;
        @(negedge CLK);
        WE = 1'b0;
        sh[i] = v;
    endtask

    // Expected timeline: each pass is one LOAD cycle followed by sum(timeout+1) RUN cycles
    task automatic build_trace(input int rep_eff, input bit inf, input int stop_at);
        int run_len, passes, rl;
        exp_q.delete();
        run_len = 0;
        for (int i = 0; i < 8; i++) run_len += int'(sh[i][1:0]) + 1;
        passes = inf ? 6 : rep_eff;
        for (int p = 0; p < passes; p++) begin
            rl = inf ? 0 : rep_eff - p;
            exp_q.push_back(mk(1, 1, 0, 0, rl));
            repeat (run_len) exp_q.push_back(mk(0, 1, 0, 0, rl));
        end
        if (stop_at >= 0 && stop_at < exp_q.size()) begin
            while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(mk(1, 0, 0, 1, 0));
        end else begin
            exp_q.push_back(mk(1, 0, 1, 0, 0));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0));
    endtask

    task automatic run_scn(input string name, input logic [7:0] rep, input int stop_at, input bit poke,
                           output int busy_cnt, output bit done_seen, output bit abort_seen);
        logic [47:0] ptn_e;
        int          rep_eff;
        bit          inf;
        ptn_e   = pack_sh();
        rep_eff = (rep == 8'd0) ? 1 : int'(rep);
        inf     = 1'b0;
`ifdef SEQ_CTRL_INFINITE_EN
        if (rep == 8'd0) begin inf = 1'b1; rep_eff = 0; end
`endif
        START = 1'b1; REP = rep;
        @(negedge CLK);
        START = 1'b0;
        build_trace(rep_eff, inf, stop_at);
        busy_cnt = 0; done_seen = 1'b0; abort_seen = 1'b0;
        for (int c = 0; c < exp_q.size(); c++) begin
            check_obs(name, c, exp_q[c], ptn_e);
            if (BUSY)  busy_cnt++;
            if (DONE)  done_seen = 1'b1;
            if (ABORT) abort_seen = 1'b1;
            STOP  = (c == stop_at);
            WE    = poke && (c == 3);
            START = poke && (c == 3);
            WADDR = 3'd3;
            WDATA = ~sh[3];
            @(negedge CLK);
            if (poke && c == 3) sh[3] = ~sh[3];
        end
        STOP = 1'b0; WE = 1'b0; START = 1'b0;
    endtask

    initial begin
        int  bc;
        bit  ds, as;
        int  stop_at;

        vecs[0] = '{16'h5555, 8'd2, -1,  1'b0, 34, 1'b1, 1'b0};
        vecs[1] = '{16'hCCCC, 8'd1, -1,  1'b0, 21, 1'b1, 1'b0};
        vecs[2] = '{16'h5555, 8'd1, 5,   1'b0, 6,  1'b0, 1'b1};
        vecs[3] = '{16'h5555, 8'd1, 16,  1'b0, 17, 1'b0, 1'b1};
        vecs[4] = '{16'h5555, 8'd2, 17,  1'b0, 18, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 8'd3, -1,  1'b0, 27, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 8'd1, -1,  1'b1, 33, 1'b1, 1'b0};
`ifdef SEQ_CTRL_INFINITE_EN
        vecs[7] = '{16'h5555, 8'd0, 101, 1'b0, 102, 1'b0, 1'b1};
`else
        vecs[7] = '{16'h5555, 8'd0, -1,  1'b0, 17, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 8; i++) sh[i] = '0;

        // reset held two cycles with START high
        RSTX = 1'b0; START = 1'b1;
        @(negedge CLK);
        check_obs("reset0", 0, mk(1, 0, 0, 0, 0), 48'h0);
        @(negedge CLK);
        check_obs("reset1", 1, mk(1, 0, 0, 0, 0), 48'h0);
        START = 1'b0; RSTX = 1'b1;
        @(negedge CLK);
        check_obs("post_reset", 0, mk(1, 0, 0, 0, 0), 48'h0);

        // START with STOP in IDLE must not launch a run
        START = 1'b1; STOP = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check_obs("start_stop_idle", c, mk(1, 0, 0, 0, 0), 48'h0);
        end
        START = 1'b0; STOP = 1'b0;
        @(negedge CLK);
        check_obs("start_stop_after", 0, mk(1, 0, 0, 0, 0), 48'h0);

        // table-driven scenarios
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 8; i++) write_entry(i, {4'(i), vecs[v].tmo[2*i +: 2]});
            run_scn($sformatf("vec%0d", v), vecs[v].rep, vecs[v].stop_at, vecs[v].poke, bc, ds, as);
            checks++;
            if (bc != vecs[v].exp_busy || ds != vecs[v].exp_done || as != vecs[v].exp_abort) begin
                failures++;
                $display("FAIL vec%0d_summary: got busy=%0d done=%b abort=%b, want busy=%0d done=%b abort=%b",
                         v, bc, ds, as, vecs[v].exp_busy, vecs[v].exp_done, vecs[v].exp_abort);
            end
            if (v == 6) begin
                // entry 3 was rewritten mid-run; the next START must pick it up
                run_scn("after_poke", 8'd1, -1, 1'b0, bc, ds, as);
            end
        end

        // randomized scenarios
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 8; i++) write_entry(i, 6'($urandom));
            stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
            run_scn($sformatf("rand%0d", r), 8'($urandom_range(1, 3)), stop_at, 1'b0, bc, ds, as);
        end

        // reset in the middle of a run
        for (int i = 0; i < 8; i++) write_entry(i, {4'(i), 2'd1});
        START = 1'b1; REP = 8'd2;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        check_obs("pre_midreset", 0, mk(0, 1, 0, 0, 2), pack_sh());
        RSTX = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) sh[i] = '0;
        check_obs("midreset", 0, mk(1, 0, 0, 0, 0), 48'h0);
        RSTX = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check_obs("after_midreset", c, mk(1, 0, 0, 0, 0), 48'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
